// File: rtl/wire_seq_gen_if.sv
// wire_seq_gen_if: start/done handshake plus stimulus/response bus of the
// wire-exercise sequencer. master = sequencer side, slave = bench/DUT side.
interface wire_seq_gen_if #(
  parameter int unsigned WIDTH = 2
);
  logic             start;
  logic [WIDTH-1:0] resp;
  logic [WIDTH-1:0] stim;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       err_count;

  modport master (
    input  start, resp,
    output stim, busy, done, err, err_count
  );

  modport slave (
    output start, resp,
    input  stim, busy, done, err, err_count
  );
endinterface

// File: rtl/wire_seq_gen.sv
// wire_seq_gen: walks WIDTH stimulus wires through all 2^WIDTH combinations
// in Gray-code order, holding each pattern for DWELL cycles, then pulses done.
// Optional loopback checker built when WIRE_SEQ_GEN_CHECK_EN is defined;
// otherwise err/err_count are tied low and resp is ignored.
module wire_seq_gen #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DWELL = 20
) (
  input  logic           clk,
  input  logic           rst,
  wire_seq_gen_if.master bus
);

  localparam int unsigned KW = WIDTH + 1;
  localparam int unsigned CW = $clog2(DWELL + 1);
  localparam logic [KW-1:0] K_LAST   = KW'((2 ** WIDTH) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State, step/dwell counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output decode; outputs follow the state being entered
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    stim_d = (state_d == S_RUN) ? WIDTH'(k_d ^ (k_d >> 1)) : '0;
  end

  assign bus.stim = stim_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef WIRE_SEQ_GEN_CHECK_EN
  logic       err_q;
  logic [7:0] err_count_q;
  logic       seq_start_c;
  logic       check_c;

  assign seq_start_c = (state_q == S_IDLE) && bus.start;
  assign check_c     = (state_q == S_RUN) && (cnt_q == CNT_LAST);

  // Sticky mismatch flag and saturating count, sampled on each step's last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else if (seq_start_c) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else if (check_c && (bus.resp != stim_q)) begin
      err_q <= 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
`else
  logic unused_resp;

  assign unused_resp   = ^bus.resp;
  assign bus.err       = 1'b0;
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_wire_seq_gen.sv
// tb_wire_seq_gen: directed bench for wire_seq_gen (WIDTH=2/DWELL=4 and
// WIDTH=8/DWELL=1 instances). Expectations adapt to WIRE_SEQ_GEN_CHECK_EN.
module tb_wire_seq_gen;

`ifdef WIRE_SEQ_GEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [1:0] G2 [4] = '{2'd0, 2'd1, 2'd3, 2'd2};

  logic clk = 1'b0;
  logic rst;
  int   mode_a;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wire_seq_gen_if #(.WIDTH(2)) if_a ();
  wire_seq_gen_if #(.WIDTH(8)) if_b ();

  // Response models: 0 loopback, 1 bit1 stuck at 0, 2 inverted
  assign if_a.resp = (mode_a == 1) ? {1'b0, if_a.stim[0]} :
                     (mode_a == 2) ? ~if_a.stim : if_a.stim;
  assign if_b.resp = ~if_b.stim;

  wire_seq_gen #(.WIDTH(2), .DWELL(4)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.master)
  );

  wire_seq_gen #(.WIDTH(8), .DWELL(1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.master)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] resp_model(input int mode, input logic [1:0] s);
    if (mode == 1) return {1'b0, s[0]};
    if (mode == 2) return ~s;
    return s;
  endfunction

  task automatic chk_idle_a(input string tag);
    chk({tag, "_busy"}, 32'(if_a.busy), 32'd0);
    chk({tag, "_done"}, 32'(if_a.done), 32'd0);
    chk({tag, "_stim"}, 32'(if_a.stim), 32'd0);
  endtask

  // Called at busy cycle 1 of instance A; returns positioned at the done cycle
  task automatic seq_a(input int mode, input bit poke);
    int ec;
    logic [1:0] es;
    ec = 0;
    for (int c = 1; c <= 16; c++) begin
      es = G2[(c - 1) / 4];
      chk($sformatf("a_stim_c%0d", c), 32'(if_a.stim), 32'(es));
      chk($sformatf("a_busy_c%0d", c), 32'(if_a.busy), 32'd1);
      chk($sformatf("a_done_c%0d", c), 32'(if_a.done), 32'd0);
      chk($sformatf("a_errcnt_c%0d", c), 32'(if_a.err_count), CHK ? 32'(ec) : 32'd0);
      chk($sformatf("a_err_c%0d", c), 32'(if_a.err), (CHK && ec != 0) ? 32'd1 : 32'd0);
      if (poke && c == 7) if_a.start = 1'b1;
      if (poke && c == 8) if_a.start = 1'b0;
      if ((c % 4) == 0 && resp_model(mode, es) != es && ec < 255) ec++;
      step();
    end
    chk("a_done_pulse", 32'(if_a.done), 32'd1);
    chk("a_done_busy", 32'(if_a.busy), 32'd0);
    chk("a_done_stim", 32'(if_a.stim), 32'd0);
    chk("a_done_errcnt", 32'(if_a.err_count), CHK ? 32'(ec) : 32'd0);
    chk("a_done_err", 32'(if_a.err), (CHK && ec != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic pulse_start_a();
    if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
  endtask

  initial begin
    logic [7:0] gb;
    rst        = 1'b1;
    mode_a     = 0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    repeat (3) step();

    // Reset state
    chk_idle_a("rst_a");
    chk("rst_a_err", 32'(if_a.err), 32'd0);
    chk("rst_a_errcnt", 32'(if_a.err_count), 32'd0);
    chk("rst_b_busy", 32'(if_b.busy), 32'd0);
    chk("rst_b_stim", 32'(if_b.stim), 32'd0);
    rst = 1'b0;
    step();
    chk_idle_a("idle0");

    // Basic sequence with loopback
    pulse_start_a();
    seq_a(0, 1'b0);
    step();
    chk_idle_a("s1_after");

    // Stuck-at bit1: mismatches on patterns 3 and 2
    mode_a = 1;
    pulse_start_a();
    seq_a(1, 1'b0);
    chk("s2_final_errcnt", 32'(if_a.err_count), CHK ? 32'd2 : 32'd0);
    chk("s2_final_err", 32'(if_a.err), CHK ? 32'd1 : 32'd0);
    step();
    chk("s2_hold_errcnt", 32'(if_a.err_count), CHK ? 32'd2 : 32'd0);

    // New start clears checker; then reset at busy cycle 6
    pulse_start_a();
    chk("s3_clr_err", 32'(if_a.err), 32'd0);
    chk("s3_clr_errcnt", 32'(if_a.err_count), 32'd0);
    repeat (5) step();
    chk("s3_c6_stim", 32'(if_a.stim), 32'd1);
    chk("s3_c6_busy", 32'(if_a.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_a("s3_rst");
    chk("s3_rst_err", 32'(if_a.err), 32'd0);
    chk("s3_rst_errcnt", 32'(if_a.err_count), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("s3_nodone_%0d", i), 32'(if_a.done), 32'd0);
      chk($sformatf("s3_nobusy_%0d", i), 32'(if_a.busy), 32'd0);
    end
    mode_a = 0;
    pulse_start_a();
    seq_a(0, 1'b0);
    step();

    // start mid-run is ignored and not queued
    pulse_start_a();
    seq_a(0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle_a($sformatf("s4_noq_%0d", i));
    end

    // start held high: done cycle, one IDLE cycle, next sequence
    if_a.start = 1'b1;
    step();
    seq_a(0, 1'b0);
    step();
    chk_idle_a("s5_gap");
    step();
    seq_a(0, 1'b0);
    if_a.start = 1'b0;
    step();
    chk_idle_a("s5_end0");
    step();
    chk_idle_a("s5_end1");

    // WIDTH=8, DWELL=1, inverted response: saturating count
    if_b.start = 1'b1;
    step();
    if_b.start = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      gb = 8'(c - 1);
      gb = gb ^ (gb >> 1);
      chk($sformatf("b_stim_c%0d", c), 32'(if_b.stim), 32'(gb));
      chk($sformatf("b_busy_c%0d", c), 32'(if_b.busy), 32'd1);
      chk($sformatf("b_errcnt_c%0d", c), 32'(if_b.err_count),
          CHK ? 32'((c - 1) > 255 ? 255 : (c - 1)) : 32'd0);
      step();
    end
    chk("b_done_pulse", 32'(if_b.done), 32'd1);
    chk("b_done_busy", 32'(if_b.busy), 32'd0);
    chk("b_done_stim", 32'(if_b.stim), 32'd0);
    chk("b_sat_errcnt", 32'(if_b.err_count), CHK ? 32'd255 : 32'd0);
    chk("b_sat_err", 32'(if_b.err), CHK ? 32'd1 : 32'd0);
    step();
    chk("b_after_done", 32'(if_b.done), 32'd0);
    chk("b_after_errcnt", 32'(if_b.err_count), CHK ? 32'd255 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
